// File: rtl/norm_shifter_pkg.sv
// Shared types and constants for the leading-zero normalizer.
package norm_shifter_pkg;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 6;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CNT_W-1:0]  inc;
        logic              norm;
    } step_t;
endpackage

// File: rtl/norm_shifter_if.sv
// Request/response bundle between a requester and norm_shifter.
interface norm_shifter_if;
    import norm_shifter_pkg::*;
    logic              in_start;
    logic [DATA_W-1:0] in_data;
    logic              out_busy;
    logic              out_done;
    logic [DATA_W-1:0] out_data;
    logic [DATA_W-1:0] out_cnt;
    logic              out_zero;

    modport master (output in_start, in_data,
                    input  out_busy, out_done, out_data, out_cnt, out_zero);
    modport slave  (input  in_start, in_data,
                    output out_busy, out_done, out_data, out_cnt, out_zero);
endinterface

// File: rtl/norm_shifter_step.sv
// One normalization step: next working value and count increment.
// NORM_SHIFTER_FAST_EN adds the 8-position skip over an all-zero top byte.
module norm_step
    import norm_shifter_pkg::*;
(
    input  logic [DATA_W-1:0] work,
    output step_t             step
);
    always_comb begin
        step.norm = work[DATA_W-1];
        step.data = {work[DATA_W-2:0], 1'b0};
        step.inc  = CNT_W'(1);
`ifdef NORM_SHIFTER_FAST_EN
        if (work[DATA_W-1 -: 8] == 8'h00) begin
            step.data = {work[DATA_W-9:0], 8'h00};
            step.inc  = CNT_W'(8);
        end
`endif
    end
endmodule

// File: rtl/norm_shifter.sv
// Iterative left-normalizer: IDLE -> SHIFT -> DONE, reports shift count.
// Build option NORM_SHIFTER_FAST_EN enables 8-bit steps (see norm_step).
module norm_shifter
    import norm_shifter_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    norm_shifter_if.slave bus
);
    state_t            state;
    logic [DATA_W-1:0] work;
    logic [CNT_W-1:0]  cnt;
    logic              busy, done, zero;
    step_t             step;

    norm_step u_step (.work(work), .step(step));

    // work doubles as the result register; it holds through IDLE until the next start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            work  <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            zero  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (bus.in_start) begin
                        busy <= 1'b1;
                        if (bus.in_data != '0) begin
                            work  <= bus.in_data;
                            cnt   <= '0;
                            zero  <= 1'b0;
                            state <= ST_SHIFT;
                        end else begin
                            work  <= '0;
                            cnt   <= CNT_W'(DATA_W);
                            zero  <= 1'b1;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (step.norm) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        work <= step.data;
                        cnt  <= cnt + step.inc;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.out_busy = busy;
    assign bus.out_done = done;
    assign bus.out_data = work;
    assign bus.out_cnt  = {{(DATA_W-CNT_W){1'b0}}, cnt};
    assign bus.out_zero = zero;
endmodule

// File: tb/tb_norm_shifter.sv
// Scoreboard bench for norm_shifter: random and directed operands vs a leading-zero model.
module tb_norm_shifter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        logic [31:0] data;
        int          cnt;
        bit          zero;
        int          done_edge;
    } exp_t;

    exp_t exp_q[$];
    exp_t last;

    norm_shifter_if bus();
    norm_shifter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic int lead_zeros(logic [31:0] d);
        for (int i = 31; i >= 0; i--)
            if (d[i]) return 31 - i;
        return 32;
    endfunction

    function automatic int latency(int k);
        if (k == 32) return 1;
`ifdef NORM_SHIFTER_FAST_EN
        return k / 8 + k % 8 + 2;
`else
        return k + 2;
`endif
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // monitor: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (rst_n && bus.out_done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_data", bus.out_data, e.data);
                chk("out_cnt", bus.out_cnt, e.cnt);
                chk("out_zero", bus.out_zero, e.zero);
                chk("done_edge", cyc, e.done_edge);
            end
        end
    end

    // caller sits at a negedge; returns at the negedge of the IDLE cycle after DONE
    task automatic run(logic [31:0] d, bit inject);
        exp_t e;
        int   k, it;
        k = lead_zeros(d);
        e.data = (k == 32) ? 32'h0 : (d << k);
        e.cnt = k;
        e.zero = (k == 32);
        e.done_edge = cyc + 1 + latency(k) - 1;
        exp_q.push_back(e);
        last = e;
        bus.in_start = 1'b1;
        bus.in_data = d;
        @(negedge clk);
        bus.in_start = 1'b0;
        chk("busy_after_start", bus.out_busy, 1);
        it = 0;
        while (!bus.out_done && it < 60) begin
            @(negedge clk);
            it++;
            bus.in_start = inject && (it == 3);
            if (bus.in_start) bus.in_data = 32'hFFFF_FFFF;
        end
        bus.in_start = 1'b0;
        if (!bus.out_done) begin
            chk("done_timeout", 0, 1);
        end else begin
            @(negedge clk);
            chk("hold_busy", bus.out_busy, 0);
            chk("hold_data", bus.out_data, last.data);
            chk("hold_cnt", bus.out_cnt, last.cnt);
        end
    endtask

    initial begin
        logic [31:0] d;
        bus.in_start = 1'b0;
        bus.in_data = '0;
        #12;
        chk("rst_busy", bus.out_busy, 0);
        chk("rst_done", bus.out_done, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_cnt", bus.out_cnt, 0);
        chk("rst_zero", bus.out_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run(32'h8000_0000, 0);
        run(32'h0000_0001, 0);
        run(32'h0000_0000, 0);
        chk("zero_hold", bus.out_zero, 1);
        run(32'h0001_2345, 1);
        chk("nonzero_clears_zero", bus.out_zero, 0);

        // abort mid-operation with a half-cycle reset pulse at edge 5
        exp_q.push_back('{32'hF000_0000, 24, 0, cyc + latency(24)});
        bus.in_start = 1'b1;
        bus.in_data = 32'h0000_00F0;
        @(negedge clk);
        bus.in_start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("abort_busy", bus.out_busy, 0);
        chk("abort_data", bus.out_data, 0);
        chk("abort_cnt", bus.out_cnt, 0);
        chk("abort_zero", bus.out_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("abort_idle", bus.out_busy, 0);
        run(32'h4000_0000, 0);

        run(32'h2000_0000, 0);
        run(32'h1000_0000, 0);

        repeat (40) begin
            if ($urandom_range(0, 7) == 0) d = 32'h0;
            else d = $urandom >> $urandom_range(0, 31);
            run(d, $urandom_range(0, 1) == 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/norm_shifter.md
NORM_SHIFTER -- requirements
Module: norm_shifter

Interface
REQ-001 The module SHALL have exactly these ports:
  clk  input  1  single clock; all state updates on rising edge.
  rst_n  input  1  asynchronous, active-low reset.
  in_start  input  1  request; sampled only in IDLE.
  in_data  input  32  operand to normalize; sampled with in_start.
  out_busy  output  1  high in SHIFT and DONE states.
  out_done  output  1  one-cycle pulse, high only in DONE.
  out_data  output  32  operand shifted left until bit 31 = 1, or 0 for a zero operand.
  out_cnt  output  32  number of positions shifted (0..32), zero-extended for direct register writeback.
  out_zero  output  1  high when the captured operand was 0.

Function
REQ-002 The block SHALL be a three-state FSM: IDLE, SHIFT, DONE.
REQ-003 In IDLE with in_start=1 and in_data!=0, the block SHALL load the working register with in_data, clear the counter and enter SHIFT at the next edge.
REQ-004 In IDLE with in_start=1 and in_data==0, the block SHALL enter DONE at the next edge with out_data=0, out_cnt=32 and out_zero=1.
REQ-005 In SHIFT with working bit 31 = 1, the block SHALL enter DONE at the next edge without shifting.
REQ-006 In SHIFT with working bit 31 = 0, the block SHALL shift the working register left by 1 (zero fill), increment the counter by 1, and stay in SHIFT.
REQ-007 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-008 Without the fast option, for a nonzero operand with k leading zeros, out_done SHALL be high in the cycle following the (k+2)th rising edge counted from the start-sampling edge (edge 1).
  - Zero operand: out_done SHALL be high after edge 1.
REQ-009 in_start SHALL be ignored while out_busy=1; the captured operand SHALL NOT be altered.
REQ-010 out_data, out_cnt and out_zero SHALL be valid in DONE and SHALL hold their values through IDLE until the next accepted start.
  - out_zero SHALL clear on a nonzero start.
REQ-011 A start accepted in the IDLE cycle immediately after DONE SHALL be honoured (back-to-back throughput).
REQ-012 The counter SHALL never exceed 32, and out_cnt[31:6] SHALL always be 0.

Reset
REQ-013 On rst_n=0, independent of clk, the block SHALL enter IDLE and drive out_busy=0, out_done=0, out_data=0, out_cnt=0, out_zero=0.
REQ-014 Reset asserted mid-operation SHALL abort the operation; no out_done pulse SHALL follow reset release until a new start.
REQ-015 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-016 Macro NORM_SHIFTER_FAST_EN SHALL select the fast shift step.
  - Defined: in SHIFT, when working bits [31:24] are all 0, the block SHALL shift by 8 and add 8 to the counter; otherwise it SHALL apply REQ-005/REQ-006.
  - Latency for k leading zeros then SHALL be floor(k/8) + (k mod 8) + 2 edges.
  - Undefined: only 1-bit steps; the 8-bit path SHALL NOT be synthesized.
  - Results SHALL be identical in both builds; only latency differs.

Structure
REQ-017 The shared CPU package SHALL hold the FSM state encoding and the constant DATA_W=32.
REQ-018 A single combinational sub-module, norm_step, SHALL compute the next working value and the count increment (1, or 8 under the fast option).

Verification
REQ-019 The bench SHALL cover these directed scenarios:
  - Start with in_data=32'h8000_0000 -> done after edge 2; out_data=32'h8000_0000, out_cnt=0, out_zero=0.
  - Start with in_data=32'h0000_0001 -> out_data=32'h8000_0000, out_cnt=31; done after edge 33 (fast build: edge 12).
  - Start with in_data=0 -> done after edge 1; out_data=0, out_cnt=32, out_zero=1.
  - Start with 32'h0001_2345, then pulse in_start with 32'hFFFF_FFFF while busy -> out_data=32'h91A2_8000, out_cnt=15; the second request is ignored.
  - Start with 32'h0000_00F0, then drop rst_n low for half a cycle at edge 5 -> all outputs 0, state IDLE, no done pulse; a following start with 32'h4000_0000 gives out_cnt=1.
  - Two back-to-back starts (32'h2000_0000, then 32'h1000_0000 in the cycle after DONE) -> out_cnt=2, then out_cnt=3, each with exactly one done pulse.
